fpadd_param_pipe: RTL and testbench
===================================

// Module: fpadd_param_pipe
// PURPOSE
//  Parametrised IEEE-754 floating-point add/subtract unit, next generation of the team's FP32 adder.
//  Configurable exponent/mantissa widths; FP32 is the default.
//  3-stage pipeline with valid/ready flow control, a per-operation add/sub mode and round-to-nearest-even.
//  Handles special values and reports status flags. Sits between the operand issue logic and the result writeback in the FPU.
// PARAMETERS
//  EXP_W   8    exponent width; bias = 2^(EXP_W-1)-1
//  MAN_W   23   stored mantissa width (hidden bit not included)
//  W       EXP_W+MAN_W+1 (localparam) total operand width
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-low reset
//  in_valid   in   1   operand pair valid
//  in_ready   out  1   unit can accept this cycle
//  in_op      in   1   0 = A+B, 1 = A-B (B sign inverted before compute)
//  in_a       in   W   operand A
//  in_b       in   W   operand B
//  out_valid  out  1   result valid
//  out_ready  in   1   downstream accepts result
//  out_res    out  W   result
//  out_flags  out  4   {invalid, overflow, underflow, inexact}
// BEHAVIOUR
//  Reset (reset==0 at posedge clk): all stage valids, out_valid, out_res and out_flags go to 0.
//   Any in-flight operations are discarded. in_ready reads 1 in the cycle after reset.
//  Handshake:
//   - Input transfers when in_valid && in_ready.
//   - Output transfers when out_valid && out_ready.
//   - in_ready = !(out_valid && !out_ready). The pipeline stalls globally: while stalled, every stage register holds.
//   - Empty stages do not block; bubbles advance freely.
//  Latency: exactly 3 cycles from accept to out_valid when there is no stall.
//   Throughput is 1 op per cycle. out_res/out_flags stay stable while out_valid && !out_ready.
//  S1 align:
//   - Effective sign of B is b_s ^ in_op.
//   - Swap so the larger-magnitude operand (by {exp, man}) is X.
//   - Shift Y's significand {1, man} right by d = eX - eY, keeping guard, round and sticky bits.
//   - When d >= MAN_W+3, all of Y goes to sticky.
//   - Classify special values here.
//  S2 compute:
//   - Same effective sign: add, giving an (MAN_W+5)-bit sum. Otherwise subtract, X-Y >= 0.
//   - Leading-zero count on the result; result sign = sign of X.
//  S3 normalise/round/pack:
//   - Carry out: shift right 1 and exp+1; the shifted-out bit ORs into sticky.
//   - Leading zeros: shift left by LZC and exp-LZC.
//   - Round to nearest even: increment when G && (R || S || LSB). A mantissa carry from rounding adds exp+1.
//   - inexact = G|R|S.
//  Zero/subnormal:
//   - Input exponent 0 is treated as signed zero (flush-to-zero).
//   - An exact-zero difference returns +0.
//   - Result exponent <= 0 returns signed zero, with underflow=1 and inexact=1.
//  Overflow: result exponent >= 2^EXP_W-1 returns signed infinity, with overflow=1 and inexact=1.
//  Specials (exp all ones), with precedence NaN > Inf:
//   - Any NaN input returns canonical qNaN {0, all-ones exp, 1, 0...}; invalid=1 only for a signalling NaN.
//   - Inf + (-Inf) after the op is applied returns qNaN with invalid=1.
//   - Otherwise Inf returns that Inf, with no flags.
//  x + 0 returns x exactly, with no flags. (+0)+(-0) returns +0; (-0)+(-0) returns -0.
//  Reset asserted during a stall drops the held result; no transfer occurs that cycle.
// TESTING
//  1) Basic add, default params:
//     in_a=0x3F800000, in_b=0x3F800000, op=0 -> out_res=0x40000000, flags=0, out_valid 3 cycles after accept.
//  2) Subtract and cancellation:
//     0x40400000 - 0x3F800000 -> 0x40000000.
//     0x3F800000 - 0x3F800000 -> 0x00000000 (+0), flags=0.
//  3) RNE ties:
//     0x3F800000 + 0x33800000 -> 0x3F800000, inexact=1.
//     0x3F800001 + 0x33800000 -> 0x3F800002, inexact=1.
//  4) Specials and overflow:
//     0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags=0101.
//     0x7F800000 + 0xFF800000 -> 0x7FC00000, flags=1000.
//  5) Backpressure:
//     stream 6 back-to-back ops with out_ready low for cycles 4-7 -> in_ready low while out_valid held,
//     all 6 results in order with none lost or duplicated, out_res stable during the stall.
//  6) Reset mid-stream and params:
//     reset=0 with 2 ops in flight -> out_valid=0 next cycle and no stale output.
//     Rerun 1-3 with EXP_W=5, MAN_W=10 (FP16): 0x3C00+0x3C00 -> 0x4000.

Source files
------------

// File: rtl/fpadd_param_pipe.sv
// Parametrised IEEE-754 add/subtract, three register stages (align, compute, round/pack)
// under a single global stall. Subnormal inputs are flushed to zero; specials bypass the datapath.
module fpadd_param_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_res,
    output logic [3:0]   out_flags
);
    localparam int AL_W   = MAN_W + 4;
    localparam int SUM_W  = MAN_W + 5;
    localparam int SH_W   = 2 * MAN_W + 4;
    localparam int LZC_W  = $clog2(SUM_W + 1);
    localparam int EXPI_W = EXP_W + LZC_W + 1;
    localparam logic signed [EXPI_W-1:0] ONE_I     = EXPI_W'(1);
    localparam logic signed [EXPI_W-1:0] ZERO_I    = '0;
    localparam logic signed [EXPI_W-1:0] EXP_MAX_I = EXPI_W'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Valid/ready: input moves on in_valid && in_ready, output on out_valid && out_ready;
    // a held output freezes every stage, otherwise all stages (bubbles included) advance.
    logic advance;
    assign advance  = !(out_valid_q && !out_ready);
    assign in_ready = advance;

    logic         s1_valid_q, s2_valid_q, out_valid_q;
    logic         s1_spec_q, s1_spec_d, s2_spec_q;
    logic [W-1:0] s1_spec_res_q, s1_spec_res_d, s2_spec_res_q;
    logic [3:0]   s1_spec_flags_q, s1_spec_flags_d, s2_spec_flags_q;
    logic         s1_sign_q, s1_sign_d, s2_sign_q;
    logic [EXP_W-1:0] s1_exp_q, s1_exp_d, s2_exp_q;
    logic [AL_W-1:0]  s1_xsig_q, s1_xsig_d, s1_ysig_q, s1_ysig_d;
    logic         s1_sub_q, s1_sub_d;
    logic [SUM_W-1:0] s2_sum_q, s2_sum_d;
    logic [LZC_W-1:0] s2_lzc_q, s2_lzc_d;
    logic [W-1:0] out_res_q, out_res_d;
    logic [3:0]   out_flags_q, out_flags_d;

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic             a_s, b_s, x_s;
    logic [EXP_W-1:0] a_e, b_e, x_e, y_e, d;
    logic [MAN_W-1:0] a_m, b_m, x_m, y_m;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic [SH_W-1:0]  sh_out;

    always_comb begin
        a_s = in_a[W-1];
        a_e = in_a[W-2 -: EXP_W];
        a_m = in_a[MAN_W-1:0];
        b_s = in_b[W-1] ^ in_op;
        b_e = in_b[W-2 -: EXP_W];
        b_m = in_b[MAN_W-1:0];

        a_zero = (a_e == '0);
        b_zero = (b_e == '0);
        a_inf  = (a_e == '1) && (a_m == '0);
        b_inf  = (b_e == '1) && (b_m == '0);
        a_nan  = (a_e == '1) && (a_m != '0);
        b_nan  = (b_e == '1) && (b_m != '0);
        a_snan = a_nan && !a_m[MAN_W-1];
        b_snan = b_nan && !b_m[MAN_W-1];

        s1_spec_d       = 1'b1;
        s1_spec_flags_d = 4'b0000;
        if (a_nan || b_nan) begin
            s1_spec_res_d   = QNAN;
            s1_spec_flags_d = {a_snan || b_snan, 3'b000};
        end else if (a_inf && b_inf && (a_s != b_s)) begin
            s1_spec_res_d   = QNAN;
            s1_spec_flags_d = 4'b1000;
        end else if (a_inf) begin
            s1_spec_res_d = {a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            s1_spec_res_d = {b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            s1_spec_res_d = {a_s & b_s, {(W-1){1'b0}}};
        end else if (a_zero) begin
            s1_spec_res_d = {b_s, b_e, b_m};
        end else if (b_zero) begin
            s1_spec_res_d = {a_s, a_e, a_m};
        end else begin
            s1_spec_d     = 1'b0;
            s1_spec_res_d = '0;
        end

        if ({a_e, a_m} >= {b_e, b_m}) begin
            x_s = a_s; x_e = a_e; x_m = a_m; y_e = b_e; y_m = b_m;
        end else begin
            x_s = b_s; x_e = b_e; x_m = b_m; y_e = a_e; y_m = a_m;
        end
        d      = x_e - y_e;
        sh_out = {1'b1, y_m, {(MAN_W+3){1'b0}}} >> d;

        s1_sign_d = x_s;
        s1_exp_d  = x_e;
        s1_sub_d  = a_s ^ b_s;
        s1_xsig_d = {1'b1, x_m, 3'b000};
        if (32'(d) >= 32'(MAN_W + 3)) begin
            s1_ysig_d = {{(AL_W-1){1'b0}}, 1'b1};
        end else begin
            s1_ysig_d = {sh_out[SH_W-1 -: MAN_W+3], |sh_out[MAN_W:0]};
        end
    end

    // ---------------- S2: add/subtract magnitudes, leading-zero count ----------------
    always_comb begin
        if (s1_sub_q) begin
            s2_sum_d = {1'b0, s1_xsig_q} - {1'b0, s1_ysig_q};
        end else begin
            s2_sum_d = {1'b0, s1_xsig_q} + {1'b0, s1_ysig_q};
        end
        s2_lzc_d = LZC_W'(SUM_W);
        for (int i = 0; i < SUM_W; i++) begin
            if (s2_sum_d[i]) s2_lzc_d = LZC_W'(SUM_W - 1 - i);
        end
    end

    // ---------------- S3: normalise, round to nearest even, pack ----------------
    logic [MAN_W+2:0]         norm;
    logic [MAN_W-1:0]         mant;
    logic [MAN_W:0]           rnd;
    logic                     g, r, st, inc;
    logic signed [EXPI_W-1:0] exp_n;

    always_comb begin
        exp_n = $signed({{(EXPI_W-EXP_W){1'b0}}, s2_exp_q});
        if (s2_sum_q[SUM_W-1]) begin
            norm  = {s2_sum_q[MAN_W+3:2], s2_sum_q[1] | s2_sum_q[0]};
            exp_n = exp_n + ONE_I;
        end else begin
            norm  = (MAN_W+3)'(s2_sum_q << (s2_lzc_q - LZC_W'(1)));
            exp_n = exp_n - $signed({{(EXPI_W-LZC_W){1'b0}}, s2_lzc_q}) + ONE_I;
        end
        mant = norm[MAN_W+2:3];
        g    = norm[2];
        r    = norm[1];
        st   = norm[0];
        inc  = g & (r | st | mant[0]);
        rnd  = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
        if (rnd[MAN_W]) exp_n = exp_n + ONE_I;

        if (s2_spec_q) begin
            out_res_d   = s2_spec_res_q;
            out_flags_d = s2_spec_flags_q;
        end else if (s2_sum_q == '0) begin
            out_res_d   = '0;
            out_flags_d = 4'b0000;
        end else if (exp_n <= ZERO_I) begin
            out_res_d   = {s2_sign_q, {(W-1){1'b0}}};
            out_flags_d = 4'b0011;
        end else if (exp_n >= EXP_MAX_I) begin
            out_res_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            out_flags_d = 4'b0101;
        end else begin
            out_res_d   = {s2_sign_q, exp_n[EXP_W-1:0], rnd[MAN_W-1:0]};
            out_flags_d = {3'b000, g | r | st};
        end
    end

    // Control and output registers carry reset; the datapath payload only loads on advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_flags_q <= '0;
        end else if (advance) begin
            s1_valid_q  <= in_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_res_q   <= out_res_d;
                out_flags_q <= out_flags_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_spec_q       <= s1_spec_d;
            s1_spec_res_q   <= s1_spec_res_d;
            s1_spec_flags_q <= s1_spec_flags_d;
            s1_sign_q       <= s1_sign_d;
            s1_exp_q        <= s1_exp_d;
            s1_xsig_q       <= s1_xsig_d;
            s1_ysig_q       <= s1_ysig_d;
            s1_sub_q        <= s1_sub_d;
            s2_spec_q       <= s1_spec_q;
            s2_spec_res_q   <= s1_spec_res_q;
            s2_spec_flags_q <= s1_spec_flags_q;
            s2_sign_q       <= s1_sign_q;
            s2_exp_q        <= s1_exp_q;
            s2_sum_q        <= s2_sum_d;
            s2_lzc_q        <= s2_lzc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign out_flags = out_flags_q;
endmodule

// File: tb/tb_fpadd_param_pipe.sv
// Directed bench for fpadd_param_pipe: FP32 instance plus an FP16 instance,
// hand-computed results, backpressure and reset-in-flight scenarios.
module tb_fpadd_param_pipe;
    logic        clk;
    logic        reset;
    logic        in_valid, in_ready, in_op, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_res;
    logic [3:0]  out_flags;
    logic        h_in_valid, h_in_ready, h_in_op, h_out_valid, h_out_ready;
    logic [15:0] h_in_a, h_in_b, h_out_res;
    logic [3:0]  h_out_flags;

    int n_asserts = 0;
    int n_fail    = 0;

    fpadd_param_pipe u_dut32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_flags(out_flags)
    );

    fpadd_param_pipe #(.EXP_W(5), .MAN_W(10)) u_dut16 (
        .clk(clk), .reset(reset),
        .in_valid(h_in_valid), .in_ready(h_in_ready), .in_op(h_in_op),
        .in_a(h_in_a), .in_b(h_in_b),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .out_res(h_out_res), .out_flags(h_out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One operation on either instance; checks accept, 3-cycle latency, result and flags.
    task automatic run_op(input bit h, input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic [31:0] er, input logic [3:0] ef);
        int lat;
        @(negedge clk);
        if (h) begin
            h_in_valid = 1'b1; h_in_a = a[15:0]; h_in_b = b[15:0]; h_in_op = op; h_out_ready = 1'b1;
        end else begin
            in_valid = 1'b1; in_a = a; in_b = b; in_op = op; out_ready = 1'b1;
        end
        check({tag, " in_ready"}, {31'b0, h ? h_in_ready : in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        h_in_valid = 1'b0;
        in_valid   = 1'b0;
        lat = 1;
        while (!(h ? h_out_valid : out_valid) && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd3);
        check({tag, " res"}, h ? {16'b0, h_out_res} : out_res, er);
        check({tag, " flags"}, {28'b0, h ? h_out_flags : out_flags}, {28'b0, ef});
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] bp_a[6];
    logic [31:0] held_res;
    logic        held_valid, acc;
    int          sent, got, stall_seen, extra, lat;

    initial begin
        reset = 1'b0;
        in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_in_op = 1'b0; h_in_a = '0; h_in_b = '0; h_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset out_res", out_res, 32'd0);
        check("reset out_flags", {28'b0, out_flags}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        check("reset h_in_ready", {31'b0, h_in_ready}, 32'd1);

        // FP32 directed vectors
        run_op(0, "1+1",        32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
        run_op(0, "3-1",        32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
        run_op(0, "1-1",        32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
        run_op(0, "tie even",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
        run_op(0, "tie odd",    32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
        run_op(0, "round up",   32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001);
        run_op(0, "borrow",     32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'b0000);
        run_op(0, "overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
        run_op(0, "inf-inf",    32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
        run_op(0, "inf sub",    32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
        run_op(0, "inf+1",      32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000);
        run_op(0, "snan",       32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
        run_op(0, "qnan",       32'h3F800000, 32'h7FC00000, 1'b0, 32'h7FC00000, 4'b0000);
        run_op(0, "x+0",        32'h40490FDB, 32'h00000000, 1'b0, 32'h40490FDB, 4'b0000);
        run_op(0, "0-x",        32'h00000000, 32'h40490FDB, 1'b1, 32'hC0490FDB, 4'b0000);
        run_op(0, "+0+-0",      32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000);
        run_op(0, "-0+-0",      32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
        run_op(0, "underflow",  32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011);

        // Backpressure: six back-to-back ops, out_ready low in cycles 4..7
        bp_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        exp_q = {32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};
        sent = 0; got = 0; stall_seen = 0; held_valid = 1'b0; held_res = '0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c <= 7);
            in_valid  = (sent < 6);
            if (sent < 6) in_a = bp_a[sent];
            in_b  = 32'h3F800000;
            in_op = 1'b0;
            #1;
            if (out_valid && !out_ready) begin
                check("bp in_ready low", {31'b0, in_ready}, 32'd0);
                stall_seen++;
                if (held_valid) check("bp res stable", out_res, held_res);
                held_valid = 1'b1;
                held_res   = out_res;
            end else begin
                held_valid = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) check("bp result", out_res, exp_q.pop_front());
                got++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("bp received", 32'(got), 32'd6);
        check("bp stall cycles", 32'(stall_seen), 32'd4);
        check("bp extra outputs", 32'(extra), 32'd0);

        // Reset with two ops in flight
        @(negedge clk);
        in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h3F800000; in_op = 1'b0;
        @(negedge clk);
        in_a = 32'h40000000;
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rst flight out_valid", {31'b0, out_valid}, 32'd0);
        reset = 1'b1;
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("rst no stale output", 32'(extra), 32'd0);
        check("rst in_ready", {31'b0, in_ready}, 32'd1);

        // Reset while a result is held by backpressure
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 32'h40400000; in_b = 32'h3F800000; in_op = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("stall held res", out_res, 32'h40800000);
        check("stall in_ready", {31'b0, in_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("stall rst out_valid", {31'b0, out_valid}, 32'd0);
        check("stall rst out_res", out_res, 32'd0);
        reset = 1'b1;
        out_ready = 1'b1;

        // FP16 instance
        run_op(1, "h 1+1",      32'h3C00, 32'h3C00, 1'b0, 32'h4000, 4'b0000);
        run_op(1, "h 3-1",      32'h4200, 32'h3C00, 1'b1, 32'h4000, 4'b0000);
        run_op(1, "h 1-1",      32'h3C00, 32'h3C00, 1'b1, 32'h0000, 4'b0000);
        run_op(1, "h tie even", 32'h3C00, 32'h1000, 1'b0, 32'h3C00, 4'b0001);
        run_op(1, "h tie odd",  32'h3C01, 32'h1000, 1'b0, 32'h3C02, 4'b0001);
        run_op(1, "h overflow", 32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 4'b0101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
